// File: rtl/camera_controller_pkg.sv
// Shared definitions for the camera controller slice.
//  - float_t : signed Q8.8 fixed-point scalar used by the camera basis
//  - vector_t: packed (x,y,z) triple of float_t
//  - FP_*    : common fixed-point constants (0, 1, -1, +/-sqrt(2)/2)
//  - *_KEY   : keyboard codes understood by the controller (6..11 rotate, 12 resets)
//  - cam_state_e: controller FSM states
package camera_controller_pkg;

  localparam int FP_W = 16;

  typedef logic signed [FP_W-1:0] float_t;

  typedef struct packed {
    float_t x;
    float_t y;
    float_t z;
  } vector_t;

  localparam float_t FP_0   = 16'sh0000;
  localparam float_t FP_1   = 16'sh0100;
  localparam float_t FP_N1  = 16'shFF00;
  localparam float_t FP_R2  = 16'sh00B5;
  localparam float_t FP_NR2 = 16'shFF4B;

  localparam logic [3:0] L_KEY   = 4'd6;
  localparam logic [3:0] J_KEY   = 4'd7;
  localparam logic [3:0] O_KEY   = 4'd8;
  localparam logic [3:0] U_KEY   = 4'd9;
  localparam logic [3:0] I_KEY   = 4'd10;
  localparam logic [3:0] K_KEY   = 4'd11;
  localparam logic [3:0] RST_KEY = 4'd12;

  localparam vector_t VEC_ZERO = '{x: FP_0, y: FP_0, z: FP_0};
  localparam vector_t DEF_U    = '{x: FP_1, y: FP_0, z: FP_0};
  localparam vector_t DEF_V    = '{x: FP_0, y: FP_1, z: FP_0};
  localparam vector_t DEF_W    = '{x: FP_0, y: FP_0, z: FP_1};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_APPLY,
    ST_PUBLISH
  } cam_state_e;

  function automatic logic is_cam_key(input logic [3:0] k);
    return (k >= L_KEY) && (k <= RST_KEY);
  endfunction

  function automatic logic is_rot_key(input logic [3:0] k);
    return (k >= L_KEY) && (k <= K_KEY);
  endfunction

  function automatic logic is_zero_vec(input vector_t v);
    return v == VEC_ZERO;
  endfunction

endpackage

// File: rtl/camera_controller_key_fifo.sv
// key_fifo: small synchronous FIFO for key events.
// Ports:
//  clk, rst_n  clock, synchronous active-low reset (pointers only)
//  push, din   write request / data; accepted when not full, or when a pop
//              happens in the same cycle
//  pop, dout   read request / head of queue (combinational)
//  full, empty occupancy flags
//  one_left    exactly one entry stored, lets the consumer see that its pop
//              will drain the queue without waiting a cycle
module key_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         one_left
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [AW:0]  level;
  logic         do_push;
  logic         do_pop;

  assign level    = wr_ptr - rd_ptr;
  assign empty    = (level == '0);
  assign full     = (level == (AW+1)'(DEPTH));
  assign one_left = (level == (AW+1)'(1));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign dout     = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/camera_controller.sv
// camera_controller: owns the live camera basis (U,V,W).
// Queues rotation/reset key events, applies them one per cycle through the
// external camera_rotator at frame boundaries, then offers the new basis to
// the ray generator with a valid/ready handshake.
// Ports:
//  clk, rst_n             clock, synchronous active-low reset
//  key, key_strobe        key code and 1-cycle new-press pulse
//  frame_done             1-cycle pulse: renderer finished a frame
//  rot_key                key code to camera_rotator (0 outside APPLY)
//  rot_U/V/W, rot_valid   camera_rotator result
//  cam_U/V/W              registered camera basis
//  cam_valid, cam_ready   basis handshake towards the ray generator
//  key_ovf                sticky: a key was dropped on a full queue
//  dbg_applied/dropped    only with CAM_DBG_CNT_EN defined: wrapping counters
//                         of basis loads and of dropped/guard-skipped keys
module camera_controller
  import camera_controller_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int MAX_PER_FRAME = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  key,
  input  logic        key_strobe,
  input  logic        frame_done,
  output logic [3:0]  rot_key,
  input  vector_t     rot_U,
  input  vector_t     rot_V,
  input  vector_t     rot_W,
  input  logic        rot_valid,
  output vector_t     cam_U,
  output vector_t     cam_V,
  output vector_t     cam_W,
  output logic        cam_valid,
  input  logic        cam_ready,
`ifdef CAM_DBG_CNT_EN
  output logic [15:0] dbg_applied,
  output logic [15:0] dbg_dropped,
`endif
  output logic        key_ovf
);

  localparam int NW = $clog2(MAX_PER_FRAME + 1);

  cam_state_e    state;
  cam_state_e    state_nxt;
  logic [NW-1:0] n_q;
  logic [NW-1:0] n_nxt;

  logic       push_req;
  logic       push_ok;
  logic       ovf_drop;
  logic       pop;
  logic [3:0] head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_one;
  logic       guard_hit;
  logic       load_rot;
  logic       load_rst;

  key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (4)
  ) u_key_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_req),
    .pop      (pop),
    .din      (key),
    .dout     (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .one_left (fifo_one)
  );

  assign push_req  = key_strobe && is_cam_key(key);
  assign pop       = (state == ST_APPLY) && !fifo_empty;
  assign ovf_drop  = push_req && fifo_full && !pop;
  assign push_ok   = push_req && !ovf_drop;
  assign rot_key   = (state == ST_APPLY) ? head : 4'd0;
  assign cam_valid = (state == ST_PUBLISH);

  // An all-zero basis vector means the rotator produced garbage; keep the
  // current basis rather than collapse the camera.
  assign guard_hit = is_zero_vec(rot_U) || is_zero_vec(rot_V) || is_zero_vec(rot_W);
  assign load_rot  = pop && is_rot_key(head) && rot_valid && !guard_hit;
  assign load_rst  = pop && (head == RST_KEY);

  always_comb begin
    state_nxt = state;
    n_nxt     = n_q;
    case (state)
      ST_IDLE: begin
        if (frame_done && !fifo_empty) begin
          state_nxt = ST_APPLY;
          n_nxt     = '0;
        end
      end
      ST_APPLY: begin
        n_nxt = n_q + NW'(1);
        // Leave in the same cycle as the last pop so cam_valid follows it
        // directly; a same-cycle push keeps the queue alive.
        if (fifo_empty || (fifo_one && !push_ok) || (n_q == NW'(MAX_PER_FRAME - 1)))
          state_nxt = ST_PUBLISH;
      end
      ST_PUBLISH: begin
        if (cam_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_PUBLISH;
      n_q     <= '0;
      key_ovf <= 1'b0;
      cam_U   <= DEF_U;
      cam_V   <= DEF_V;
      cam_W   <= DEF_W;
    end else begin
      state <= state_nxt;
      n_q   <= n_nxt;
      if (ovf_drop) key_ovf <= 1'b1;
      if (load_rst) begin
        cam_U <= DEF_U;
        cam_V <= DEF_V;
        cam_W <= DEF_W;
      end else if (load_rot) begin
        cam_U <= rot_U;
        cam_V <= rot_V;
        cam_W <= rot_W;
      end
    end
  end

`ifdef CAM_DBG_CNT_EN
  logic guard_skip;

  assign guard_skip = pop && is_rot_key(head) && rot_valid && guard_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dbg_applied <= '0;
      dbg_dropped <= '0;
    end else begin
      dbg_applied <= dbg_applied + {15'd0, (load_rot || load_rst)};
      dbg_dropped <= dbg_dropped + {15'd0, ovf_drop} + {15'd0, guard_skip};
    end
  end
`endif

endmodule

// File: tb/tb_camera_controller.sv
// Directed bench for camera_controller. The bench itself plays the role of
// camera_rotator, driving hand-picked rot_U/V/W values during APPLY cycles.
// Honours CAM_DBG_CNT_EN for the optional debug counters.
module tb_camera_controller;
  import camera_controller_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [3:0]  key;
  logic        key_strobe;
  logic        frame_done;
  logic [3:0]  rot_key;
  vector_t     rot_U;
  vector_t     rot_V;
  vector_t     rot_W;
  logic        rot_valid;
  vector_t     cam_U;
  vector_t     cam_V;
  vector_t     cam_W;
  logic        cam_valid;
  logic        cam_ready;
  logic        key_ovf;
`ifdef CAM_DBG_CNT_EN
  logic [15:0] dbg_applied;
  logic [15:0] dbg_dropped;
`endif

  int passed;
  int failed;
  int total;

  camera_controller #(
    .FIFO_DEPTH    (4),
    .MAX_PER_FRAME (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key         (key),
    .key_strobe  (key_strobe),
    .frame_done  (frame_done),
    .rot_key     (rot_key),
    .rot_U       (rot_U),
    .rot_V       (rot_V),
    .rot_W       (rot_W),
    .rot_valid   (rot_valid),
    .cam_U       (cam_U),
    .cam_V       (cam_V),
    .cam_W       (cam_W),
    .cam_valid   (cam_valid),
    .cam_ready   (cam_ready),
`ifdef CAM_DBG_CNT_EN
    .dbg_applied (dbg_applied),
    .dbg_dropped (dbg_dropped),
`endif
    .key_ovf     (key_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vector_t vec(input float_t x, input float_t y, input float_t z);
    vector_t v;
    v.x = x;
    v.y = y;
    v.z = z;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_k(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_v(input string tag, input vector_t obs, input vector_t exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

`ifdef CAM_DBG_CNT_EN
  task automatic chk_w(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
`endif

  task automatic press(input logic [3:0] k);
    key        = k;
    key_strobe = 1'b1;
    tick();
    key_strobe = 1'b0;
  endtask

  task automatic frame();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
  endtask

  logic [3:0] burst_keys [6];
  logic [3:0] exp_order  [4];

  initial begin
    passed     = 0;
    failed     = 0;
    total      = 0;
    rst_n      = 1'b0;
    key        = 4'd0;
    key_strobe = 1'b0;
    frame_done = 1'b0;
    rot_U      = VEC_ZERO;
    rot_V      = VEC_ZERO;
    rot_W      = VEC_ZERO;
    rot_valid  = 1'b0;
    cam_ready  = 1'b1;
    burst_keys = '{K_KEY, J_KEY, U_KEY, I_KEY, L_KEY, O_KEY};
    exp_order  = '{K_KEY, J_KEY, U_KEY, I_KEY};

    // Reset: initial basis offered once
    tick();
    tick();
    chk_b("rst_cam_valid", cam_valid, 1'b1);
    chk_v("rst_U", cam_U, vec(FP_1, FP_0, FP_0));
    chk_v("rst_V", cam_V, vec(FP_0, FP_1, FP_0));
    chk_v("rst_W", cam_W, vec(FP_0, FP_0, FP_1));
    chk_b("rst_key_ovf", key_ovf, 1'b0);
    chk_k("rst_rot_key", rot_key, 4'd0);
    rst_n = 1'b1;
    tick();
    chk_b("rst_valid_one_cycle", cam_valid, 1'b0);

    // Two L presses, then a frame boundary: two APPLY cycles
    press(L_KEY);
    press(L_KEY);
    cam_ready = 1'b0;
    frame();
    chk_k("l1_rot_key", rot_key, L_KEY);
    chk_b("l1_no_valid", cam_valid, 1'b0);
    rot_U     = vec(FP_R2, FP_0, FP_NR2);
    rot_V     = vec(FP_0, FP_1, FP_0);
    rot_W     = vec(FP_R2, FP_0, FP_R2);
    rot_valid = 1'b1;
    tick();
    chk_v("l1_W", cam_W, vec(FP_R2, FP_0, FP_R2));
    chk_k("l2_rot_key", rot_key, L_KEY);
    chk_b("l2_no_valid", cam_valid, 1'b0);
    rot_U = vec(FP_0, FP_0, FP_N1);
    rot_W = vec(FP_1, FP_0, FP_0);
    tick();
    rot_valid = 1'b0;
    chk_b("l2_valid", cam_valid, 1'b1);
    chk_v("l2_U", cam_U, vec(FP_0, FP_0, FP_N1));
    chk_v("l2_W", cam_W, vec(FP_1, FP_0, FP_0));
    chk_k("l2_rot_key_idle", rot_key, 4'd0);

    // Back-pressure in PUBLISH: frame_done and a key press meanwhile
    for (int i = 0; i < 10; i++) begin
      if (i == 3) frame_done = 1'b1;
      if (i == 5) begin
        key        = O_KEY;
        key_strobe = 1'b1;
      end
      tick();
      frame_done = 1'b0;
      key_strobe = 1'b0;
    end
    chk_b("bp_valid_held", cam_valid, 1'b1);
    chk_v("bp_U_stable", cam_U, vec(FP_0, FP_0, FP_N1));
    chk_v("bp_W_stable", cam_W, vec(FP_1, FP_0, FP_0));
    cam_ready = 1'b1;
    tick();
    chk_b("bp_handshake", cam_valid, 1'b0);
    tick();
    chk_k("bp_no_catchup", rot_key, 4'd0);
    frame();
    chk_k("bp_o_applied", rot_key, O_KEY);
    rot_U     = vec(FP_1, FP_0, FP_0);
    rot_V     = vec(FP_0, FP_0, FP_N1);
    rot_W     = vec(FP_0, FP_1, FP_0);
    rot_valid = 1'b1;
    tick();
    rot_valid = 1'b0;
    chk_b("bp_o_valid", cam_valid, 1'b1);
    chk_v("bp_o_V", cam_V, vec(FP_0, FP_0, FP_N1));
    tick();

    // Six presses into a 4-deep queue, then a frame boundary
    for (int i = 0; i < 6; i++) begin
      press(burst_keys[i]);
      if (i == 3) chk_b("ovf_not_yet", key_ovf, 1'b0);
      if (i == 4) chk_b("ovf_set", key_ovf, 1'b1);
    end
    chk_k("ovf_idle", rot_key, 4'd0);
    frame();
    for (int i = 0; i < 4; i++) begin
      chk_k($sformatf("ovf_order%0d", i), rot_key, exp_order[i]);
      if (i == 0) begin
        key        = L_KEY;
        key_strobe = 1'b1;
      end
      tick();
      key_strobe = 1'b0;
    end
    chk_b("max_per_frame_publish", cam_valid, 1'b1);
    chk_b("ovf_sticky", key_ovf, 1'b1);
    chk_v("no_rot_valid_U", cam_U, vec(FP_1, FP_0, FP_0));
    tick();
    frame();
    chk_k("leftover_key", rot_key, L_KEY);
    tick();
    chk_b("leftover_publish", cam_valid, 1'b1);
    tick();

    // Reset key restores default basis
    press(RST_KEY);
    frame();
    chk_k("rstkey_rot_key", rot_key, RST_KEY);
    rot_U     = vec(FP_NR2, FP_R2, FP_0);
    rot_V     = vec(FP_R2, FP_R2, FP_0);
    rot_W     = vec(FP_0, FP_0, FP_N1);
    rot_valid = 1'b1;
    tick();
    rot_valid = 1'b0;
    chk_v("rstkey_U", cam_U, vec(FP_1, FP_0, FP_0));
    chk_v("rstkey_V", cam_V, vec(FP_0, FP_1, FP_0));
    chk_v("rstkey_W", cam_W, vec(FP_0, FP_0, FP_1));
    tick();

    // Code 3 is never queued
    press(4'd3);
    frame();
    chk_k("key3_no_apply", rot_key, 4'd0);
    chk_b("key3_no_publish", cam_valid, 1'b0);

    // All-zero rotator output leaves the basis untouched
    press(L_KEY);
    frame();
    rot_U     = vec(FP_0, FP_0, FP_N1);
    rot_V     = vec(FP_0, FP_1, FP_0);
    rot_W     = VEC_ZERO;
    rot_valid = 1'b1;
    chk_k("guard_rot_key", rot_key, L_KEY);
    tick();
    rot_valid = 1'b0;
    chk_b("guard_publish", cam_valid, 1'b1);
    chk_v("guard_U", cam_U, vec(FP_1, FP_0, FP_0));
    chk_v("guard_W", cam_W, vec(FP_0, FP_0, FP_1));
    tick();

`ifdef CAM_DBG_CNT_EN
    chk_w("dbg_applied", dbg_applied, 16'd4);
    chk_w("dbg_dropped", dbg_dropped, 16'd3);
`endif

    // Reset in the middle of APPLY with three keys queued
    press(J_KEY);
    press(U_KEY);
    press(I_KEY);
    frame();
    rot_U     = vec(FP_0, FP_1, FP_0);
    rot_V     = vec(FP_1, FP_0, FP_0);
    rot_W     = vec(FP_0, FP_0, FP_N1);
    rot_valid = 1'b1;
    tick();
    chk_v("mid_apply_U", cam_U, vec(FP_0, FP_1, FP_0));
    chk_k("mid_apply_rot_key", rot_key, U_KEY);
    rst_n = 1'b0;
    tick();
    rst_n     = 1'b1;
    rot_valid = 1'b0;
    chk_b("mid_rst_valid", cam_valid, 1'b1);
    chk_v("mid_rst_U", cam_U, vec(FP_1, FP_0, FP_0));
    chk_v("mid_rst_W", cam_W, vec(FP_0, FP_0, FP_1));
    chk_b("mid_rst_ovf", key_ovf, 1'b0);
    chk_k("mid_rst_rot_key", rot_key, 4'd0);
`ifdef CAM_DBG_CNT_EN
    chk_w("mid_rst_dbg_applied", dbg_applied, 16'd0);
    chk_w("mid_rst_dbg_dropped", dbg_dropped, 16'd0);
`endif
    tick();
    frame();
    chk_k("mid_rst_fifo_empty", rot_key, 4'd0);
    chk_b("mid_rst_idle", cam_valid, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
